// File: rtl/ox_mlp_classifier.sv
// Serial 16-NH-2 MLP classifier for the 4x4 O/X keypad drawing.
// Binary inputs, ReLU/saturating hidden layer, signed O and X scores.
module ox_mlp_classifier #(
  parameter int NI    = 16,
  parameter int NH    = 8,
  parameter int NO    = 2,
  parameter int SHIFT = 0,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NI-1:0]    grid,
  input  logic             wr_en,
  input  logic [7:0]       wr_addr,
  input  logic [7:0]       wr_data,
  output logic             busy,
  output logic             done,
  output logic [1:0]       result,
  output logic [ACC_W-1:0] score_o,
  output logic [ACC_W-1:0] score_x
);

  localparam int B1_BASE = NI * NH;
  localparam int W2_BASE = B1_BASE + NH;
  localparam int B2_BASE = W2_BASE + NO * NH;
  localparam int MEM_N   = B2_BASE + NO;
  localparam int I_W     = (NI > 1) ? $clog2(NI) : 1;
  localparam int J_W     = (NH > 1) ? $clog2(NH) : 1;
  localparam int K_W     = (NO > 1) ? $clog2(NO) : 1;

  typedef enum logic [2:0] {IDLE, L1, L2, CMP, DONE} state_t;

  state_t                  state_reg;
  logic [NI-1:0]           grid_reg;
  logic [I_W-1:0]          i_reg;
  logic [J_W-1:0]          j_reg;
  logic [K_W-1:0]          k_reg;
  logic signed [15:0]      acc1_reg;
  logic [7:0]              h_reg [NH];
  logic signed [ACC_W-1:0] acc_o_reg [NO];
  logic                    busy_reg;
  logic                    done_reg;
  logic [1:0]              result_reg;
  logic [ACC_W-1:0]        score_o_reg;
  logic [ACC_W-1:0]        score_x_reg;

  // Weights are deliberately outside the reset domain so they survive rst.
  logic signed [7:0]       weight_mem [MEM_N];

  always_ff @(posedge clk) begin
    if (wr_en && !busy_reg && (int'(wr_addr) < MEM_N))
      weight_mem[wr_addr] <= wr_data;
  end

  logic [7:0]         w1_addr, b1_next_addr, w2_addr;
  logic signed [7:0]  w1_val, b1_next_val, w2_val;
  logic signed [15:0] acc1_add, acc1_sum, acc1_sh;
  logic [7:0]         h_next;
  logic signed [16:0] prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic               i_last, j_last, k_last, l1_last;

  always_comb begin
    w1_addr      = 8'(int'(j_reg) * NI + int'(i_reg));
    b1_next_addr = 8'(B1_BASE + int'(j_reg) + 1);
    w2_addr      = 8'(W2_BASE + int'(k_reg) * NH + int'(j_reg));
    w1_val       = weight_mem[w1_addr];
    b1_next_val  = weight_mem[b1_next_addr];
    w2_val       = weight_mem[w2_addr];
    acc1_add     = grid_reg[i_reg] ? {{8{w1_val[7]}}, w1_val} : 16'sd0;
    acc1_sum     = acc1_reg + acc1_add;
    acc1_sh      = acc1_sum >>> SHIFT;
    if (acc1_sh < 16'sd0)
      h_next = 8'd0;
    else if (acc1_sh > 16'sd255)
      h_next = 8'd255;
    else
      h_next = acc1_sh[7:0];
    // Hidden activation is unsigned, so widen with a zero before the signed multiply.
    prod     = $signed({1'b0, h_reg[j_reg]}) * w2_val;
    prod_ext = {{(ACC_W-17){prod[16]}}, prod};
    i_last   = (i_reg == I_W'(NI - 1));
    j_last   = (j_reg == J_W'(NH - 1));
    k_last   = (k_reg == K_W'(NO - 1));
    l1_last  = (state_reg == L1) && i_last && j_last;
  end

  generate
    for (genvar gi = 0; gi < NO; gi++) begin : g_out_acc
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          acc_o_reg[gi] <= '0;
        else if (l1_last)
          acc_o_reg[gi] <= {{(ACC_W-8){weight_mem[B2_BASE+gi][7]}}, weight_mem[B2_BASE+gi]};
        else if ((state_reg == L2) && (k_reg == K_W'(gi)))
          acc_o_reg[gi] <= acc_o_reg[gi] + prod_ext;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      grid_reg    <= '0;
      i_reg       <= '0;
      j_reg       <= '0;
      k_reg       <= '0;
      acc1_reg    <= '0;
      h_reg       <= '{default: '0};
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      result_reg  <= 2'b00;
      score_o_reg <= '0;
      score_x_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            grid_reg  <= grid;
            busy_reg  <= 1'b1;
            i_reg     <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
            acc1_reg  <= {{8{weight_mem[B1_BASE][7]}}, weight_mem[B1_BASE]};
            state_reg <= L1;
          end
        end
        L1: begin
          if (i_last) begin
            h_reg[j_reg] <= h_next;
            i_reg        <= '0;
            if (j_last) begin
              j_reg     <= '0;
              k_reg     <= '0;
              acc1_reg  <= '0;
              state_reg <= L2;
            end else begin
              j_reg    <= j_reg + 1'b1;
              acc1_reg <= {{8{b1_next_val[7]}}, b1_next_val};
            end
          end else begin
            i_reg    <= i_reg + 1'b1;
            acc1_reg <= acc1_sum;
          end
        end
        L2: begin
          if (j_last) begin
            j_reg <= '0;
            if (k_last)
              state_reg <= CMP;
            else
              k_reg <= k_reg + 1'b1;
          end else begin
            j_reg <= j_reg + 1'b1;
          end
        end
        CMP: begin
          score_o_reg <= acc_o_reg[0];
          score_x_reg <= acc_o_reg[1];
          if (acc_o_reg[0] > acc_o_reg[1])
            result_reg <= 2'b01;
          else if (acc_o_reg[1] > acc_o_reg[0])
            result_reg <= 2'b10;
          else
            result_reg <= 2'b00;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= DONE;
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign result  = result_reg;
  assign score_o = score_o_reg;
  assign score_x = score_x_reg;

endmodule

// File: tb/tb_ox_mlp_classifier.sv
// Directed bench for ox_mlp_classifier: hand-computed scores, latency and protocol guards.
module tb_ox_mlp_classifier;

  localparam int LAT = 16 * 8 + 2 * 8 + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] grid = '0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        busy, done;
  logic [1:0]  result;
  logic [23:0] score_o, score_x;

  int n_cmp = 0;
  int n_err = 0;

  ox_mlp_classifier dut (
    .clk(clk), .rst(rst), .start(start), .grid(grid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .result(result),
    .score_o(score_o), .score_x(score_x)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic write_w(input int addr, input int data);
    wr_en = 1'b1; wr_addr = 8'(addr); wr_data = 8'(data);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic load_all(input int w1, input int b1, input int w2o, input int w2x,
                          input int b2o, input int b2x);
    for (int a = 0; a < 128; a++) write_w(a, w1);
    for (int a = 128; a < 136; a++) write_w(a, b1);
    for (int a = 136; a < 144; a++) write_w(a, w2o);
    for (int a = 144; a < 152; a++) write_w(a, w2x);
    write_w(152, b2o);
    write_w(153, b2x);
  endtask

  // inject=1 pulses a second start plus a write to addr 0 at cycle 50 of the run.
  task automatic run(input logic [15:0] g, input bit inject, output int lat);
    start = 1'b1; grid = g;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    check("busy_after_start", int'(busy), 1);
    for (int n = 1; n <= 400; n++) begin
      if (inject && n == 50) begin
        start = 1'b1; grid = 16'hFFFF;
        wr_en = 1'b1; wr_addr = 8'd0; wr_data = 8'h9C;
      end
      @(posedge clk); #1;
      start = 1'b0; wr_en = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic expect_result(input string tag, input int lat, input int so,
                               input int sx, input int res);
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_score_o"}, int'($signed(score_o)), so);
    check({tag, "_score_x"}, int'($signed(score_x)), sx);
    check({tag, "_result"}, int'(result), res);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, int'(done), 0);
  endtask

  initial begin
    int lat;
    int done_seen;

    // Reset held across an edge with start high must stay idle.
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_score_o", int'($signed(score_o)), 0);
    check("rst_score_x", int'($signed(score_x)), 0);
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Each hidden neuron sees 4 active inputs of weight +1 -> h=4.
    load_all(1, 0, 1, -1, 0, 0);
    run(16'h000F, 1'b0, lat);
    expect_result("basic", lat, 32, -32, 1);

    run(16'h0000, 1'b0, lat);
    expect_result("tie", lat, 0, 0, 0);

    // 16*127=2032 saturates to 255; 8*255 = 2040.
    load_all(127, 0, 1, 0, 0, 0);
    run(16'hFFFF, 1'b0, lat);
    expect_result("sat", lat, 2040, 0, 1);

    // Negative pre-activation -> ReLU 0; only B2[X]=7 remains.
    load_all(-1, 0, 1, 0, 0, 7);
    run(16'hFFFF, 1'b0, lat);
    expect_result("relu", lat, 0, 7, 2);

    // Restart and write attempt mid-run must be ignored.
    load_all(1, 0, 1, -1, 0, 0);
    run(16'h000F, 1'b1, lat);
    expect_result("guard", lat, 32, -32, 1);
    run(16'h000F, 1'b0, lat);
    expect_result("guard_readback", lat, 32, -32, 1);

    write_w(200, 8'h80);
    run(16'h000F, 1'b0, lat);
    expect_result("addr200", lat, 32, -32, 1);

    // Asynchronous reset at cycle 80 aborts the run without a done pulse.
    start = 1'b1; grid = 16'h000F;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (80) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_result", int'(result), 0);
    check("abort_score_o", int'($signed(score_o)), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    done_seen = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (done) done_seen = 1;
    end
    check("abort_no_done", done_seen, 0);
    run(16'h000F, 1'b0, lat);
    expect_result("after_abort", lat, 32, -32, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
